// File: rtl/uart_hex_packer_if.sv
// ----------------------------------------------------------------------------
// uart_hex_packer_if
// Byte stream handshake between the hex packer and the UART transmitter.
//   tx_data  : byte offered to the UART
//   tx_valid : tx_data is valid
//   tx_ready : UART takes the byte in this cycle when tx_valid is also high
// Modports:
//   master : the byte producer (packer)
//   slave  : the byte consumer (UART tx)
// ----------------------------------------------------------------------------
interface uart_hex_packer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_hex_packer.sv
// ----------------------------------------------------------------------------
// uart_hex_packer
// Turns one multi-channel 16-bit sample into an ASCII-hex text line such as
// "S1234,ABCD,00FF\r\n" and streams it byte by byte to the UART transmitter.
//
// Parameters:
//   N_CH      : number of 16-bit channels per sample (1..8)
// Ports:
//   clk       : system clock
//   rst       : synchronous reset, active high
//   smp_stb   : single-cycle sample strobe
//   smp_data  : channel k at bits [16k+15:16k]
//   tx        : byte stream to the UART (master modport)
//   busy      : a frame is in progress
//   drop_cnt  : saturating count of strobes lost while busy
//
// Build option:
//   UART_HEX_PACKER_CKSUM_EN : when defined, "*HH" is inserted before CR,
//   HH being the XOR of every byte from 'S' through the last data char.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no frame, waiting for smp_stb
// HDR      | presenting 'S'
// HEX      | presenting one hex char of channel ch_q, nibble nib_q
// SEP      | presenting ',' between channels
// CKS_STAR | presenting '*' (checksum build only)
// CKS_HI   | presenting checksum high nibble (checksum build only)
// CKS_LO   | presenting checksum low nibble (checksum build only)
// CR       | presenting carriage return
// LF       | presenting line feed, may chain straight into the next frame
// ----------------------------------------------------------------------------
module uart_hex_packer #(
    parameter int N_CH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 smp_stb,
    input  logic [16*N_CH-1:0]   smp_data,
    uart_hex_packer_if.master    tx,
    output logic                 busy,
    output logic [7:0]           drop_cnt
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        HEX,
        SEP,
`ifdef UART_HEX_PACKER_CKSUM_EN
        CKS_STAR,
        CKS_HI,
        CKS_LO,
`endif
        CR,
        LF
    } state_t;

    state_t              state_q, state_nx;
    logic [CH_W-1:0]     ch_q, ch_nx;
    logic [1:0]          nib_q, nib_nx;
    logic [16*N_CH-1:0]  cap_q;
    logic [7:0]          tx_data_q, byte_nx;
    logic                tx_valid_q;
    logic                accept;
    logic                start;
    logic                drop;
    logic [7:0]          drop_q;
    logic [15:0]         words [2**CH_W];
`ifdef UART_HEX_PACKER_CKSUM_EN
    logic [7:0]          cks_q;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // nibble 0 is the most significant one, so chars come out MSB first
    function automatic logic [3:0] nib_sel(input logic [15:0] w, input logic [1:0] n);
        logic [3:0] r;
        case (n)
            2'd0:    r = w[15:12];
            2'd1:    r = w[11:8];
            2'd2:    r = w[7:4];
            default: r = w[3:0];
        endcase
        return r;
    endfunction

    // Power-of-two padded view of the captured sample so any ch index is legal
    for (genvar k = 0; k < 2**CH_W; k++) begin : g_words
        if (k < N_CH) begin : g_used
            assign words[k] = cap_q[16*k +: 16];
        end else begin : g_pad
            assign words[k] = 16'h0000;
        end
    end

    assign accept = tx_valid_q && tx.tx_ready;
    // A strobe is taken in IDLE or in the very cycle LF leaves; anything else is lost
    assign start  = smp_stb && ((state_q == IDLE) || ((state_q == LF) && accept));
    assign drop   = smp_stb && (state_q != IDLE) && !((state_q == LF) && accept);

    always_comb begin
        state_nx = state_q;
        ch_nx    = ch_q;
        nib_nx   = nib_q;
        case (state_q)
            IDLE: if (smp_stb) state_nx = HDR;
            HDR: if (accept) begin
                state_nx = HEX;
                ch_nx    = '0;
                nib_nx   = 2'd0;
            end
            HEX: if (accept) begin
                if (nib_q == 2'd3) begin
                    if (ch_q == LAST_CH) begin
`ifdef UART_HEX_PACKER_CKSUM_EN
                        state_nx = CKS_STAR;
`else
                        state_nx = CR;
`endif
                    end else begin
                        state_nx = SEP;
                    end
                end else begin
                    nib_nx = nib_q + 2'd1;
                end
            end
            SEP: if (accept) begin
                state_nx = HEX;
                ch_nx    = ch_q + 1'b1;
                nib_nx   = 2'd0;
            end
`ifdef UART_HEX_PACKER_CKSUM_EN
            CKS_STAR: if (accept) state_nx = CKS_HI;
            CKS_HI:   if (accept) state_nx = CKS_LO;
            CKS_LO:   if (accept) state_nx = CR;
`endif
            CR: if (accept) state_nx = LF;
            LF: if (accept) state_nx = smp_stb ? HDR : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The byte for the state being entered is registered alongside it, so
    // tx_data is a flop and stays put while a stall repeats the same state.
    always_comb begin
        byte_nx = 8'h00;
        case (state_nx)
            HDR:      byte_nx = 8'h53;
            HEX:      byte_nx = hex_char(nib_sel(words[ch_nx], nib_nx));
            SEP:      byte_nx = 8'h2C;
`ifdef UART_HEX_PACKER_CKSUM_EN
            CKS_STAR: byte_nx = 8'h2A;
            CKS_HI:   byte_nx = hex_char(cks_q[7:4]);
            CKS_LO:   byte_nx = hex_char(cks_q[3:0]);
`endif
            CR:       byte_nx = 8'h0D;
            LF:       byte_nx = 8'h0A;
            default:  byte_nx = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            nib_q      <= 2'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_nx;
            ch_q       <= ch_nx;
            nib_q      <= nib_nx;
            tx_data_q  <= byte_nx;
            tx_valid_q <= (state_nx != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q <= '0;
        end else if (start) begin
            cap_q <= smp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 8'h00;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'h01;
        end
    end

`ifdef UART_HEX_PACKER_CKSUM_EN
    // Accumulate every accepted byte up to the last data char; cleared as a
    // new frame header is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cks_q <= 8'h00;
        end else if (accept && ((state_q == HDR) || (state_q == HEX) || (state_q == SEP))) begin
            cks_q <= cks_q ^ tx_data_q;
        end else if ((state_nx == HDR) && (state_q != HDR)) begin
            cks_q <= 8'h00;
        end
    end
`endif

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = (state_q != IDLE);
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_uart_hex_packer.sv
module tb_uart_hex_packer;

    localparam int N_CH = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                smp_stb;
    logic [16*N_CH-1:0]  smp_data;
    logic                busy;
    logic [7:0]          drop_cnt;
    int                  n_checks = 0;
    int                  n_fail = 0;

    uart_hex_packer_if tx_if ();

    uart_hex_packer #(.N_CH(N_CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .smp_stb  (smp_stb),
        .smp_data (smp_data),
        .tx       (tx_if),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Full expected line for a hand-written body "S....,....,...."
    function automatic string frame(input string body);
`ifdef UART_HEX_PACKER_CKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < body.len(); i++) x = x ^ body[i];
        return $sformatf("%s*%c%c\015\012", body, hexc(x[7:4]), hexc(x[3:0]));
`else
        return {body, "\015\012"};
`endif
    endfunction

    task automatic strobe(input logic [16*N_CH-1:0] d);
        smp_data = d;
        smp_stb  = 1'b1;
        step();
        smp_stb  = 1'b0;
    endtask

    // rmode: 0 ready always, 1 ready one cycle in three, 2 ready one cycle in twenty
    // smode: 0 none, 1 two strobes mid-frame, 2 strobe every non-LF cycle,
    //        3 strobe in the LF acceptance cycle
    task automatic recv_frame(input string exp, input int rmode, input int smode, input bit chain);
        int         idx;
        int         cyc;
        bit         stalled;
        logic [7:0] held;
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        held = 8'h00;
        while (idx < exp.len() && cyc < 2000) begin
            case (rmode)
                0:       tx_if.tx_ready = 1'b1;
                1:       tx_if.tx_ready = ((cyc % 3) == 2);
                default: tx_if.tx_ready = ((cyc % 20) == 19);
            endcase
            smp_stb = 1'b0;
            if (smode == 1) smp_stb = (cyc == 3) || (cyc == 7);
            if (smode == 2) begin
                smp_stb  = (idx < exp.len() - 1);
                smp_data = 48'({$urandom(), $urandom()});
            end
            if (smode == 3) smp_stb = (idx == exp.len() - 1) && tx_if.tx_ready;
            check("tx_valid_in_frame", {31'b0, tx_if.tx_valid}, 32'd1);
            if (stalled) check("stall_hold", {24'b0, tx_if.tx_data}, {24'b0, held});
            if (tx_if.tx_ready) begin
                check($sformatf("byte[%0d]", idx), {24'b0, tx_if.tx_data}, {24'b0, exp[idx]});
                idx++;
            end
            stalled = !tx_if.tx_ready;
            held    = tx_if.tx_data;
            step();
            cyc++;
        end
        smp_stb = 1'b0;
        check("frame_len", idx, exp.len());
        if (chain) begin
            check("chain_valid", {31'b0, tx_if.tx_valid}, 32'd1);
            check("chain_S", {24'b0, tx_if.tx_data}, 32'h53);
            check("chain_busy", {31'b0, busy}, 32'd1);
        end else begin
            check("end_valid", {31'b0, tx_if.tx_valid}, 32'd0);
            check("end_busy", {31'b0, busy}, 32'd0);
        end
    endtask

    localparam logic [47:0] D1 = 48'h00FF_ABCD_1234;
    localparam logic [47:0] D2 = 48'h0009_F00A_BEEF;
    localparam logic [47:0] D3 = 48'hC3A5_7E81_5A0F;

    initial begin
        rst = 1'b1;
        smp_stb = 1'b0;
        smp_data = '0;
        tx_if.tx_ready = 1'b0;
        repeat (3) step();
        check("rst_valid", {31'b0, tx_if.tx_valid}, 32'd0);
        check("rst_data", {24'b0, tx_if.tx_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_drop", {24'b0, drop_cnt}, 32'd0);
        rst = 1'b0;
        step();

        // back-to-back frame; input changes after capture must not leak in
        tx_if.tx_ready = 1'b1;
        strobe(D1);
        smp_data = '1;
        recv_frame(frame("S1234,ABCD,00FF"), 0, 0, 1'b0);

        // same data with a stalling UART
        tx_if.tx_ready = 1'b0;
        strobe(D1);
        recv_frame(frame("S1234,ABCD,00FF"), 1, 0, 1'b0);
        check("drop_none", {24'b0, drop_cnt}, 32'd0);

        // two strobes lost mid-frame
        strobe(D1);
        recv_frame(frame("S1234,ABCD,00FF"), 0, 1, 1'b0);
        check("drop_two", {24'b0, drop_cnt}, 32'd2);

        // strobe during LF acceptance chains the next frame with no gap
        strobe(D1);
        smp_data = D2;
        recv_frame(frame("S1234,ABCD,00FF"), 0, 3, 1'b1);
        recv_frame(frame("SBEEF,F00A,0009"), 0, 0, 1'b0);
        check("drop_chain", {24'b0, drop_cnt}, 32'd2);

        // flood of strobes during a slow frame saturates the counter
        strobe(D1);
        recv_frame(frame("S1234,ABCD,00FF"), 2, 2, 1'b0);
        check("drop_sat", {24'b0, drop_cnt}, 32'd255);

        // reset after five bytes aborts the frame; strobe under reset ignored
        tx_if.tx_ready = 1'b1;
        strobe(D3);
        repeat (5) step();
        rst = 1'b1;
        smp_stb = 1'b1;
        step();
        check("abort_valid", {31'b0, tx_if.tx_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_drop", {24'b0, drop_cnt}, 32'd0);
        check("abort_data", {24'b0, tx_if.tx_data}, 32'd0);
        rst = 1'b0;
        smp_stb = 1'b0;
        step();
        step();
        check("post_abort_valid", {31'b0, tx_if.tx_valid}, 32'd0);
        check("post_abort_busy", {31'b0, busy}, 32'd0);
        strobe(D3);
        recv_frame(frame("S5A0F,7E81,C3A5"), 0, 0, 1'b0);

        // all-zero sample
        strobe('0);
`ifdef UART_HEX_PACKER_CKSUM_EN
        recv_frame("S0000,0000,0000*53\015\012", 0, 0, 1'b0);
`else
        recv_frame("S0000,0000,0000\015\012", 0, 0, 1'b0);
`endif
        check("final_drop", {24'b0, drop_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_hex_packer.md
# uart_hex_packer

Formats one multi-channel sample (e.g. three phase currents) into an ASCII-hex text line and streams it byte by byte into the UART transmit block. It sits directly upstream of the UART tx path: the sampling logic strobes a sample in, and the UART consumes bytes through a valid/ready handshake. Output is human-readable on a terminal: `S1234,ABCD,00FF\r\n`.

## Interface
Parameters:
- N_CH, 3, number of 16-bit channels per sample (1..8)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous reset, active high
- smp_stb  in  1  single-cycle sample strobe
- smp_data  in  16*N_CH  channel k at bits [16k+15:16k]
- tx_data  out  8  byte to UART
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts byte
- busy  out  1  frame in progress (not IDLE)
- drop_cnt  out  8  saturating count of strobes lost while busy

## Operation
- Frame byte order: 'S' (0x53); then for ch 0..N_CH-1: 4 hex chars, MSB nibble first; ',' (0x2C) between channels (not after the last); then CR (0x0D), LF (0x0A).
- Frame length: 1 + 5*N_CH - 1 + 2 bytes (17 for N_CH=3).
- Hex encoding: nibble 0–9 -> 0x30+n; A–F -> 0x41+(n-10), uppercase only.
- smp_data is captured into an internal register on smp_stb in IDLE; later input changes do not affect the frame in flight.
- FSM states: IDLE, HDR, HEX, SEP, CKS_STAR, CKS_HI, CKS_LO, CR, LF. CKS_* states exist only with the checksum macro.
  - IDLE -> HDR on smp_stb.
  - HDR -> HEX; HEX cycles through 4 nibbles, then -> SEP, or -> CR (or CKS_STAR) after the last channel.
  - SEP -> HEX (next channel); CR -> LF.
  - LF -> IDLE, or -> HDR if smp_stb arrives in that same cycle.
- Each state advances only when tx_valid && tx_ready.
- Handshake rules:
  - tx_valid is never deasserted before acceptance.
  - tx_data holds stable while tx_valid && !tx_ready.
  - tx_valid stays high through the frame when tx_ready is continuously high.
- Drops: smp_stb while busy, other than in the LF-acceptance cycle, increments drop_cnt. drop_cnt saturates at 255 and is cleared only by rst.
- busy = (state != IDLE).

## Timing
- Reset values: tx_valid=0, tx_data=0x00, busy=0, drop_cnt=0, state IDLE, capture register 0.
- Strobe in cycle 0 (IDLE) -> tx_valid=1 with 'S' in cycle 1; busy=1 from cycle 1.
- Outputs are registered. With tx_ready held high, one byte is transferred per cycle and the last byte (LF) appears in cycle 17 for N_CH=3.
- When LF is accepted in cycle n: tx_valid=0 and busy=0 in cycle n+1. If a strobe coincides with LF acceptance, the next 'S' is presented in cycle n+1 with no gap.
- rst mid-frame aborts immediately: the next cycle has tx_valid=0 and no partial-frame completion.
- smp_stb asserted while rst is high is ignored.

## Configuration
- UART_HEX_PACKER_CKSUM_EN defined: '*' (0x2A) plus two uppercase hex chars are inserted before CR.
  - Checksum = XOR of all bytes from 'S' through the last data char inclusive.
  - Frame length grows by 3 (20 for N_CH=3).
- Not defined: no checksum bytes, and no checksum register or states are synthesised.

## Test plan
- N_CH=3, data {0x1234,0xABCD,0x00FF}, tx_ready=1 -> bytes "S1234,ABCD,00FF\r\n" in cycles 1..17; busy falls in cycle 18.
- Same data, tx_ready toggling 1-of-3 cycles -> identical byte sequence; tx_data stable during every stall; no byte duplicated or skipped.
- Strobe twice mid-frame, then 300 strobes mid-frame -> drop_cnt=2, then saturates at 255; the frame in flight is unchanged.
- Strobe in the same cycle LF is accepted -> second frame's 'S' in the next cycle; drop_cnt unchanged.
- rst pulsed after 5 bytes -> tx_valid=0 and drop_cnt=0 next cycle; a new strobe produces a full fresh frame starting with 'S'.
- With UART_HEX_PACKER_CKSUM_EN, data all zero -> "S0000,0000,0000*53\r\n" (20 bytes).
